param_sipo: RTL

PARAM_SIPO -- requirements
Module: param_sipo

---
 rtl/param_sipo.sv | 113 +++++++++++
 1 files changed

// File: rtl/param_sipo.sv
// Parameterised serial-in/parallel-out capture block.
// A word capture is started by i_start, bits are qualified by i_bit_en, and the
// completed word is presented on o_data_out with a valid/ready handshake.
// Overwriting an unaccepted word sets a sticky overrun flag.
module param_sipo #(
  parameter int unsigned WIDTH     = 7,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_data_in,
  input  logic             i_bit_en,
  input  logic             i_ready,
  input  logic             i_clr_overrun,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_sr, w_sr;
  logic [WIDTH-1:0] r_data, w_data;
  logic             r_valid, w_valid;
  logic             r_overrun, w_overrun;

  logic [WIDTH-1:0] w_sr_shifted;
  logic             w_accept;
  logic             w_complete;

  // Shift register value after accepting the current serial bit.
  // LSB-first shifts right so the first bit ends up in bit 0 after WIDTH bits.
  always_comb begin
    if (MSB_FIRST) begin
      w_sr_shifted = {r_sr[WIDTH-2:0], i_data_in};
    end else begin
      w_sr_shifted = {i_data_in, r_sr[WIDTH-1:1]};
    end
  end

  // A restart takes priority over a simultaneous bit, so it blocks acceptance.
  assign w_accept   = (r_state == SHIFT) && i_bit_en && !i_start;
  assign w_complete = w_accept && (r_cnt == CW'(WIDTH - 1));

  // Next-state for capture FSM, counter and shift register.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sr    = r_sr;
    if (i_start) begin
      w_state = SHIFT;
      w_cnt   = '0;
      w_sr    = '0;
    end else if (w_accept) begin
      w_sr  = w_sr_shifted;
      w_cnt = r_cnt + CW'(1);
      if (w_complete) begin
        w_state = IDLE;
      end
    end
  end

  // Next-state for presented word, valid flag and sticky overrun.
  always_comb begin
    w_data    = r_data;
    w_valid   = r_valid;
    w_overrun = r_overrun;
    if (w_complete) begin
      w_data  = w_sr_shifted;
      w_valid = 1'b1;
    end else if (r_valid && i_ready) begin
      w_valid = 1'b0;
    end
    // Set wins over clear.
    if (w_complete && r_valid && !i_ready) begin
      w_overrun = 1'b1;
    end else if (i_clr_overrun) begin
      w_overrun = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_sr      <= w_sr;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_overrun <= w_overrun;
    end
  end

  assign o_data_out = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state == SHIFT);
  assign o_overrun  = r_overrun;

endmodule
